// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared glyph/select codes and glyph decode for the seven-segment scan receiver.
// Patterns are active-low {dp,g..a}; select codes are active-low anodes.
package seven_seg_scan_decoder_pkg;

  localparam logic [7:0] GLYPH_L   = 8'hC7;
  localparam logic [7:0] GLYPH_R   = 8'hAF;
  localparam logic [7:0] GLYPH_B   = 8'h83;
  localparam logic [7:0] GLYPH_F   = 8'h8E;
  localparam logic [7:0] GLYPH_NIL = 8'hFF;

  localparam logic [3:0] SEL_POS0  = 4'b1110;
  localparam logic [3:0] SEL_POS1  = 4'b1101;
  localparam logic [3:0] SEL_NONE  = 4'b1111;

  localparam int KEY_W = 12;

  typedef enum logic [1:0] {
    POS_NONE = 2'd0,
    POS_0    = 2'd1,
    POS_1    = 2'd2
  } pos_e;

  typedef struct packed {
    logic       known;
    logic [1:0] bits;
  } glyph_dec_t;

  function automatic pos_e decode_sel(input logic [3:0] sel);
    pos_e p;
    case (sel)
      SEL_POS0: p = POS_0;
      SEL_POS1: p = POS_1;
      default:  p = POS_NONE;
    endcase
    return p;
  endfunction

  // bits is the 2-bit COMMAND field for that position; known=0 flags a glyph error.
  function automatic glyph_dec_t decode_glyph(input pos_e pos, input logic [7:0] pat);
    glyph_dec_t d;
    d.known = 1'b1;
    d.bits  = 2'b00;
    case (pos)
      POS_0: begin
        case (pat)
          GLYPH_R:   d.bits = 2'b01;
          GLYPH_L:   d.bits = 2'b10;
          GLYPH_NIL: d.bits = 2'b00;
          default:   d.known = 1'b0;
        endcase
      end
      POS_1: begin
        case (pat)
          GLYPH_B:   d.bits = 2'b01;
          GLYPH_F:   d.bits = 2'b10;
          GLYPH_NIL: d.bits = 2'b00;
          default:   d.known = 1'b0;
        endcase
      end
      default: d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_filter.sv
// Stability filter: one-cycle accept when a key has been seen STABLE_CYCLES times in a row.
// Accept is combinational from the current sample so the caller registers the result on that edge.
module seg_stability_filter #(
  parameter int STABLE_CYCLES = 4,
  parameter int WIDTH         = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_key,
  output logic             o_accept,
  output logic [WIDTH-1:0] o_key
);

  localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

  logic [WIDTH-1:0] r_key;
  logic [7:0]       r_cnt;
  logic             w_same;
  logic [7:0]       w_cnt_next;

  always_comb begin
    w_same     = (i_key == r_key);
    w_cnt_next = 8'd1;
    if (w_same) begin
      w_cnt_next = (r_cnt >= LP_STABLE) ? r_cnt : r_cnt + 8'd1;
    end
    // Suppress re-accept while a saturated dwell continues.
    o_accept = (w_cnt_next == LP_STABLE) && !(w_same && (r_cnt == LP_STABLE));
    o_key    = i_key;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key <= '1;
      r_cnt <= 8'd0;
    end else begin
      r_key <= i_key;
      r_cnt <= w_cnt_next;
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Recovers the 4-bit direction command from a multiplexed active-low seven-segment scan bus,
// with glitch filtering, unknown-glyph flagging and per-position staleness timeout.
module seven_seg_scan_decoder
  import seven_seg_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_sel,
  input  logic [7:0] i_digit,
  output logic [3:0] o_command,
  output logic       o_valid,
  output logic       o_glyph_err,
  output logic [7:0] o_dig0,
  output logic [7:0] o_dig1
);

  localparam int         TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LP_TO     = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LP_TO_M1  = TW'(TIMEOUT_CYCLES - 1);

  logic [3:0]         r_sel_q;
  logic [7:0]         r_digit_q;
  logic               w_accept;
  logic [KEY_W-1:0]   w_acc_key;
  pos_e               w_acc_pos;
  glyph_dec_t         w_dec;
  logic [1:0]         w_acc;

  logic [3:0]         r_cmd, w_cmd_next;
  logic [1:0]         r_fresh, w_fresh_next;
  logic [1:0][TW-1:0] r_to, w_to_next;
  logic [1:0][7:0]    r_dig, w_dig_next;
  logic               r_err, w_err_next;
  logic               r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel_q   <= SEL_NONE;
      r_digit_q <= GLYPH_NIL;
    end else begin
      r_sel_q   <= i_sel;
      r_digit_q <= i_digit;
    end
  end

  seg_stability_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .WIDTH         (KEY_W)
  ) u_filter (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_key    ({r_sel_q, r_digit_q}),
    .o_accept (w_accept),
    .o_key    (w_acc_key)
  );

  always_comb begin
    w_acc_pos = decode_sel(w_acc_key[11:8]);
    w_dec     = decode_glyph(w_acc_pos, w_acc_key[7:0]);
    w_acc[0]  = w_accept && (w_acc_pos == POS_0);
    w_acc[1]  = w_accept && (w_acc_pos == POS_1);
  end

  always_comb begin
    w_cmd_next   = r_cmd;
    w_fresh_next = r_fresh;
    w_to_next    = r_to;
    w_dig_next   = r_dig;
    w_err_next   = 1'b0;
    for (int p = 0; p < 2; p++) begin
      // Accept takes priority over a timeout landing on the same cycle.
      if (w_acc[p]) begin
        w_to_next[p]    = '0;
        w_fresh_next[p] = 1'b1;
        w_dig_next[p]   = w_acc_key[7:0];
        if (w_dec.known) begin
          w_cmd_next[2*p +: 2] = w_dec.bits;
        end else begin
          w_err_next = 1'b1;
        end
      end else if (r_to[p] != LP_TO) begin
        w_to_next[p] = r_to[p] + TW'(1);
        if (r_to[p] == LP_TO_M1) begin
          w_cmd_next[2*p +: 2] = 2'b00;
          w_dig_next[p]        = GLYPH_NIL;
          w_fresh_next[p]      = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd   <= 4'b0000;
      r_fresh <= 2'b00;
      r_to    <= {LP_TO, LP_TO};
      r_dig   <= {GLYPH_NIL, GLYPH_NIL};
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_cmd   <= w_cmd_next;
      r_fresh <= w_fresh_next;
      r_to    <= w_to_next;
      r_dig   <= w_dig_next;
      r_err   <= w_err_next;
      r_valid <= &w_fresh_next;
    end
  end

  assign o_command   = r_cmd;
  assign o_valid     = r_valid;
  assign o_glyph_err = r_err;
  assign o_dig0      = r_dig[0];
  assign o_dig1      = r_dig[1];

endmodule
